// File: rtl/axi_intr_ctrl_n.sv
// AXI4-Lite interrupt controller: GIE/IER/ISR/IAR/IPR/ILR, edge or level sources.
// Define INTR_SW_TRIGGER_EN to enable the ISET software-trigger register at 0x18.
module axi_intr_ctrl_n #(
  parameter int          C_NUM_OF_INTR      = 4,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_INTR_MODE_RST    = 32'h0,
  parameter bit          C_IRQ_SENSITIVITY  = 1'b1,
  parameter bit          C_IRQ_ACTIVE_STATE = 1'b1,
  parameter int          C_SYNC_STAGES      = 2
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_NUM_OF_INTR-1:0]        intr_in,
  output logic                            irq
);
  localparam int N = C_NUM_OF_INTR;
  localparam int S = C_SYNC_STAGES;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e wst_q;
  rstate_e rst_q;
  logic awready_q, bvalid_q, arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic [S-1:0][N-1:0] sync_q;
  logic [N-1:0] prev_q, ier_q, ier_d, ilr_q, ilr_d, isr_q, isr_d;
  logic         gie_q, gie_d, any_q, irq_q;
  logic [N-1:0] src, hw_set, clr, ipr;
  logic         wr, any;
  logic [2:0]   wsel;
  logic [31:0]  rd;
`ifdef INTR_SW_TRIGGER_EN
  logic [N-1:0] iset;
`endif

  always_comb begin
    src    = sync_q[S-1];
    hw_set = (ilr_q & src) | (~ilr_q & src & ~prev_q);
    wr     = awready_q;
    wsel   = S_AXI_AWADDR[4:2];
    gie_d  = gie_q;
    ier_d  = ier_q;
    ilr_d  = ilr_q;
    clr    = '0;
`ifdef INTR_SW_TRIGGER_EN
    iset   = '0;
`endif
    if (wr) begin
      case (wsel)
        3'd0: if (S_AXI_WSTRB[0]) gie_d = S_AXI_WDATA[0];
        3'd1: for (int i = 0; i < N; i++)
                if (S_AXI_WSTRB[i/8]) ier_d[i] = S_AXI_WDATA[i];
        3'd3: clr = S_AXI_WDATA[N-1:0];
        3'd5: for (int i = 0; i < N; i++)
                if (S_AXI_WSTRB[i/8]) ilr_d[i] = S_AXI_WDATA[i];
`ifdef INTR_SW_TRIGGER_EN
        3'd6: iset = S_AXI_WDATA[N-1:0];
`endif
        default: ;
      endcase
    end
    // set beats clear on the same bit
`ifdef INTR_SW_TRIGGER_EN
    isr_d = (isr_q & ~clr) | hw_set | iset;
`else
    isr_d = (isr_q & ~clr) | hw_set;
`endif
    ipr = isr_q & ier_q;
    any = gie_q & (|ipr);
  end

  always_comb begin
    rd = '0;
    case (S_AXI_ARADDR[4:2])
      3'd0: rd[0]     = gie_q;
      3'd1: rd[N-1:0] = ier_q;
      3'd2: rd[N-1:0] = isr_q;
      3'd4: rd[N-1:0] = ipr;
      3'd5: rd[N-1:0] = ilr_q;
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      sync_q <= '0;
      prev_q <= '0;
      gie_q  <= 1'b0;
      ier_q  <= '0;
      ilr_q  <= C_INTR_MODE_RST[N-1:0];
      isr_q  <= '0;
      any_q  <= 1'b0;
      irq_q  <= ~C_IRQ_ACTIVE_STATE;
    end else begin
      sync_q <= (S > 1) ? {sync_q[S-2:0], intr_in} : intr_in;
      prev_q <= src;
      gie_q  <= gie_d;
      ier_q  <= ier_d;
      ilr_q  <= ilr_d;
      isr_q  <= isr_d;
      any_q  <= any;
      if (C_IRQ_SENSITIVITY)
        irq_q <= any ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
      else
        irq_q <= (any & ~any_q) ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      unique case (wst_q)
        W_IDLE: begin
          if (awready_q) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            wst_q     <= W_RESP;
          end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
            awready_q <= 1'b1;
          end
        end
        W_RESP: if (S_AXI_BREADY) begin
          bvalid_q <= 1'b0;
          wst_q    <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (rst_q)
        R_IDLE: begin
          if (arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd;
            rst_q     <= R_DATA;
          end else if (S_AXI_ARVALID) begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: if (S_AXI_RREADY) begin
          rvalid_q <= 1'b0;
          rst_q    <= R_IDLE;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WDATA,
                       S_AXI_WSTRB, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_q;
endmodule

// File: tb/tb_axi_intr_ctrl_n.sv
// Directed self-checking bench for axi_intr_ctrl_n (N=4, edge reset mode,
// level irq active-high, 2 sync stages).
module tb_axi_intr_ctrl_n;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  intr = '0;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_intr_ctrl_n dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .intr_in(intr), .irq(irq)
  );

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) begin
      total++; bad++;
      $display("FAIL wr_awready_timeout addr=%h", a);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!bvalid || bresp !== 2'b00) begin
      bad++;
      $display("FAIL wr_bresp addr=%h got bvalid=%b bresp=%b want 1/00",
               a, bvalid, bresp);
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) begin
      total++; bad++;
      $display("FAIL rd_arready_timeout addr=%h", a);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) begin
      total++; bad++;
      $display("FAIL rd_rvalid_timeout addr=%h", a);
    end
    d = rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({awready, wready, bvalid, arready, rvalid, irq} !== 6'b0 ||
        rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got %b rdata=%h want 0",
               {awready, wready, bvalid, arready, rvalid, irq}, rdata);
    end
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      axi_read(5'(r * 4), d);
      total++;
      if (d !== 32'h0) begin
        bad++;
        $display("FAIL reset_reg%0d got %h want 0", r, d);
      end
    end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h1, 4'hF);
    @(negedge clk); intr[0] = 1'b1;
    @(negedge clk); intr[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL edge_irq_early got %b want 0", irq);
    end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL edge_irq_latency got %b want 1", irq);
    end
    axi_read(5'h08, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL edge_isr got %h want 1", d); end
    axi_read(5'h10, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL edge_ipr got %h want 1", d); end
    axi_write(5'h0C, 32'h1, 4'h0);
    axi_read(5'h10, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL edge_ipr_ack got %h want 0", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL edge_irq_ack got %b want 0", irq); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    axi_write(5'h14, 32'h2, 4'h1);
    axi_write(5'h04, 32'h2, 4'h1);
    axi_write(5'h04, 32'hF, 4'h0);
    axi_read(5'h04, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL level_wstrb_ier got %h want 2", d); end
    intr[1] = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL level_irq got %b want 1", irq); end
    axi_write(5'h0C, 32'h2, 4'hF);
    axi_read(5'h08, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL level_reset_isr got %h want 2", d); end
    intr[1] = 1'b0;
    repeat (5) @(negedge clk);
    axi_write(5'h0C, 32'h2, 4'hF);
    axi_read(5'h08, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL level_clear_isr got %h want 0", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL level_irq_off got %b want 0", irq); end
  endtask

  task automatic test_masked();
    logic [31:0] d;
    logic seen;
    axi_write(5'h04, 32'h0, 4'hF);
    seen = 1'b0;
    @(negedge clk); intr[2] = 1'b1;
    @(negedge clk); intr[2] = 1'b0;
    repeat (6) begin @(negedge clk); seen |= irq; end
    axi_read(5'h08, d);
    seen |= irq;
    total++;
    if (d !== 32'h4) begin bad++; $display("FAIL mask_isr got %h want 4", d); end
    axi_read(5'h10, d);
    seen |= irq;
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL mask_ipr got %h want 0", d); end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL mask_irq got %b want 0", seen); end
    axi_write(5'h04, 32'h4, 4'hF);
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_enable got %b want 1", irq); end
    axi_write(5'h0C, 32'h4, 4'hF);
    axi_write(5'h04, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic seen;
    int n;
    @(negedge clk);
    awaddr = 5'h14; wdata = 32'h5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    wdata = 32'h3;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= awready; end
    total++;
    if (seen !== 1'b0 || bvalid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_stall got awready_seen=%b bvalid=%b want 0/1",
               seen, bvalid);
    end
    bready = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!awready || bvalid) begin
      bad++;
      $display("FAIL b2b_second_aw got awready=%b bvalid=%b want 1/0",
               awready, bvalid);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    axi_read(5'h14, d);
    total++;
    if (d !== 32'h3) begin bad++; $display("FAIL b2b_ilr got %h want 3", d); end
    axi_read(5'h1C, d);
    total++;
    if (d !== 32'h0 || rresp !== 2'b00) begin
      bad++;
      $display("FAIL unmapped_read got %h resp=%b want 0/00", d, rresp);
    end
  endtask

  task automatic test_sw_trigger();
    logic [31:0] d;
    axi_write(5'h18, 32'h8, 4'hF);
    axi_write(5'h04, 32'h8, 4'hF);
    @(negedge clk);
    axi_read(5'h08, d);
`ifdef INTR_SW_TRIGGER_EN
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL iset_isr got %h want 8", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL iset_irq got %b want 1", irq); end
`else
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL iset_isr got %h want 0", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL iset_irq got %b want 0", irq); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int n;
    @(negedge clk);
    araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (rvalid !== 1'b0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got rvalid=%b irq=%b want 0/0", rvalid, irq);
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_idle got rvalid=%b bvalid=%b want 0/0",
               rvalid, bvalid);
    end
    axi_read(5'h00, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_mid_gie got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_masked();
    test_back_to_back();
    test_sw_trigger();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_intr_ctrl_n.md
# axi_intr_ctrl_n

Parametrised AXI4-Lite interrupt controller gathering up to 32 peripheral interrupt sources (UART RX/TX, timers, GPIO) into one `irq` line for the processor. Provides a global enable, per-source enable, raw status, pending, acknowledge and per-source edge/level mode registers. It replaces the fixed single-source interrupt slave attached to each peripheral IP.

## Interface
- `C_NUM_OF_INTR`, 4: number of sources, 1..32.
- `C_S_AXI_DATA_WIDTH`, 32: fixed at 32.
- `C_S_AXI_ADDR_WIDTH`, 5: byte address width; bits [4:2] select the register.
- `C_INTR_MODE_RST`, 0: reset value of the ILR register. Per bit, 1 = level, 0 = edge.
- `C_IRQ_SENSITIVITY`, 1: 1 = `irq` is a held level; 0 = `irq` is a one-cycle pulse.
- `C_IRQ_ACTIVE_STATE`, 1: polarity of `irq` when active.
- `C_SYNC_STAGES`, 2: synchroniser depth on `intr_in`, 2..4.

Ports:
- `S_AXI_ACLK` in 1: the single clock.
- `S_AXI_ARESET` in 1: asynchronous reset, active-high.
- `S_AXI_AWADDR` in ADDR_W; `S_AXI_AWPROT` in 3 (ignored); `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1.
- `S_AXI_WDATA` in 32; `S_AXI_WSTRB` in 4; `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1.
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1.
- `S_AXI_ARADDR` in ADDR_W; `S_AXI_ARPROT` in 3 (ignored); `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1.
- `S_AXI_RDATA` out 32; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1.
- `intr_in` in C_NUM_OF_INTR: asynchronous interrupt sources, active-high.
- `irq` out 1: combined interrupt output.

## Operation
Register map. Only bits [N-1:0] are implemented; unimplemented bits read 0.
- 0x00 GIE: bit0 is the global enable.
- 0x04 IER: per-source enable.
- 0x08 ISR: raw status, read-only.
- 0x0C IAR: write-1-to-clear ISR bits; reads 0.
- 0x10 IPR: ISR & IER, read-only.
- 0x14 ILR: per-source mode.
- 0x18 ISET: see Configuration.
- 0x1C and any unmapped address: read 0, writes ignored.

Write rules:
- WSTRB is honoured per byte on GIE, IER and ILR.
- IAR and ISET act on all bytes regardless of WSTRB.

Source path:
- Each `intr_in` bit passes through `C_SYNC_STAGES` flops.
- Edge mode: a synchronised 0→1 transition sets ISR[i].
- Level mode: ISR[i] is set on every cycle the synchronised input is 1.
- ISR is set regardless of IER. IER only gates IPR and `irq`.
- If set and clear hit the same bit in the same cycle, set wins.
- In level mode an acknowledged bit re-sets on the next cycle while the input stays high.

IRQ generation: `any = GIE[0] & |IPR`.
- Level sensitivity: `irq = any ? ACTIVE : ~ACTIVE`.
- Pulse sensitivity: `irq` is ACTIVE for one cycle on each 0→1 transition of `any`.

AXI write handshake, states W_IDLE → W_RESP:
- In W_IDLE, when AWVALID and WVALID are both high, assert AWREADY and WREADY together for exactly one cycle, perform the register update, and move to W_RESP.
- In W_RESP, BVALID is held until BREADY, then return to W_IDLE.
- No new address or data is accepted while BVALID is high.

AXI read handshake, states R_IDLE → R_DATA:
- In R_IDLE, ARVALID causes a one-cycle ARREADY, RDATA is registered, and the FSM moves to R_DATA.
- In R_DATA, RVALID and RDATA are held stable until RREADY.

BRESP and RRESP are always 2'b00.

## Timing
- Reset values:
  - All registers 0, except ILR = C_INTR_MODE_RST.
  - Synchronisers 0.
  - All READY and VALID outputs 0; RDATA 0.
  - `irq` = ~C_IRQ_ACTIVE_STATE.
- Input edge to ISR bit set: C_SYNC_STAGES+1 cycles.
- ISR set to `irq` active: 1 cycle, because `irq` is registered.
- Write: AWREADY/WREADY in the cycle after both VALIDs are sampled. The register value is visible and BVALID is asserted in the following cycle.
- Read: ARREADY 1 cycle after ARVALID; RVALID 1 cycle after ARREADY.
- A read of ISR or IPR returns the value sampled in the ARREADY cycle.
- A write to IAR clears the bit in the same cycle the register update happens. `irq` deasserts 1 cycle later if nothing else is pending.
- Reset asserted mid-transaction aborts it immediately. After release the bus sits idle with no stale BVALID or RVALID.

## Configuration
- `INTR_SW_TRIGGER_EN` defined:
  - Writing 1 to ISET bit i sets ISR[i], as if the source had fired.
  - Set-over-clear priority also applies between ISET and IAR.
- Not defined: 0x18 behaves as unmapped (reads 0, writes ignored) and no ISET logic is generated.

## Test plan
- Reset, then read every register → 0, except ILR = C_INTR_MODE_RST; `irq` inactive.
- N=4, all edge mode. Write GIE=1, IER=0x1, pulse `intr_in[0]` for 1 cycle → ISR=0x1, IPR=0x1, `irq` active. Write IAR=0x1 → IPR reads 0x0, `irq` inactive.
- Set ILR=0x2 and IER=0x2, hold `intr_in[1]` high. Write IAR=0x2 → ISR[1] reads 1 again. Release the input, write IAR=0x2 → ISR=0.
- Pulse `intr_in[2]` with IER=0x0 → ISR=0x4, IPR=0x0, `irq` never active. Then set IER=0x4 → `irq` active.
- Back-to-back writes while holding BREADY low for 5 cycles → second AWREADY does not appear until B completes. Read of 0x1C → RDATA=0, RRESP=0.
- With `INTR_SW_TRIGGER_EN`: write ISET=0x8 and IER=0x8 → `irq` active. Without the macro: the same write leaves ISR=0.
